multi_cycle_ctrl: RTL and testbench

MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

---
 rtl/multi_cpu_pkg.sv | 66 ++++++
 rtl/mem_wait_timer.sv | 31 +++
 rtl/multi_cycle_ctrl.sv | 167 ++++++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_cpu_pkg.sv
// Shared encodings for the multi-cycle CPU control path: FSM state codes,
// opcodes, datapath mux encodings and the ID-stage opcode decoder.
// Optional feature macro: MULTI_CTRL_JAL_EN (enables the JAL state).
package multi_cpu_pkg;

  typedef enum logic [3:0] {
    S_IF  = 4'd0,
    S_ID  = 4'd1,
    S_MA  = 4'd2,
    S_MRD = 4'd3,
    S_MWB = 4'd4,
    S_MWR = 4'd5,
    S_REX = 4'd6,
    S_RWB = 4'd7,
    S_BEQ = 4'd8,
    S_JMP = 4'd9,
    S_IEX = 4'd10,
    S_IWB = 4'd11,
    S_JAL = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_IMM   = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BRANCH = 2'b11;

  // ID-stage dispatch; S_IF as the result marks an illegal opcode.
  function automatic state_e decode_op(input logic [5:0] op);
    state_e s;
    case (op)
      OP_RTYPE:        s = S_REX;
      OP_LW, OP_SW:    s = S_MA;
      OP_BEQ:          s = S_BEQ;
      OP_J:            s = S_JMP;
      OP_ADDI, OP_ORI: s = S_IEX;
`ifdef MULTI_CTRL_JAL_EN
      OP_JAL:          s = S_JAL;
`endif
      default:         s = S_IF;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait timer: counts consecutive stalled cycles while run is high and
// flags expiry combinationally on the MEM_TIMEOUT-th stalled cycle.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic expired
);

  localparam int unsigned CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

  logic [CW-1:0] r_count;

  // Stall counter; clear has priority so an expiry restarts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (run) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign expired = run && (r_count == LAST);

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle CPU main control FSM. Control outputs are decoded
// combinationally from state, cpu_en and mem_ready; mem_err is registered.
// Optional feature macro: MULTI_CTRL_JAL_EN (adds the JAL state).
module multi_cycle_ctrl
  import multi_cpu_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_en,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic [1:0] ALUSrcB,
  output logic [1:0] RegDst,
  output logic [3:0] state,
  output logic       illegal,
  output logic       mem_err
);

  state_e r_state;
  logic   r_mem_err;
  state_e w_decoded;
  logic   w_wait_state;
  logic   w_run;
  logic   w_clr;
  logic   w_expired;

  assign w_decoded    = decode_op(op);
  assign w_wait_state = ((r_state == S_IF) && cpu_en) ||
                        (r_state == S_MRD) || (r_state == S_MWR);
  assign w_run        = w_wait_state && !mem_ready;
  // Any non-stalled cycle is either a state change or breaks the stall run.
  assign w_clr        = !w_run || w_expired;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (w_clr),
    .run     (w_run),
    .expired (w_expired)
  );

  // State register and timeout error pulse; a timeout overrides any transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IF;
      r_mem_err <= 1'b0;
    end else begin
      r_mem_err <= w_expired;
      if (w_expired) begin
        r_state <= S_IF;
      end else begin
        case (r_state)
          S_IF:    if (cpu_en && mem_ready) r_state <= S_ID;
          S_ID:    r_state <= w_decoded;
          S_MA:    r_state <= (op == OP_LW) ? S_MRD : S_MWR;
          S_MRD:   if (mem_ready) r_state <= S_MWB;
          S_MWR:   if (mem_ready) r_state <= S_IF;
          S_REX:   r_state <= S_RWB;
          S_IEX:   r_state <= S_IWB;
          default: r_state <= S_IF;
        endcase
      end
    end
  end

  // Per-state control decode; everything not named for a state stays 0.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    PCSource    = PCSRC_ALU;
    ALUOp       = ALUOP_ADD;
    ALUSrcB     = SRCB_REG;
    RegDst      = REGDST_RT;
    illegal     = 1'b0;
    case (r_state)
      S_IF: begin
        MemRead = cpu_en;
        ALUSrcB = SRCB_FOUR;
        PCWrite = cpu_en && mem_ready;
        IRWrite = cpu_en && mem_ready;
      end
      S_ID: begin
        ALUSrcB = SRCB_BRANCH;
        illegal = (w_decoded == S_IF);
      end
      S_MA: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MRD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      S_MWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        RegDst   = REGDST_RT;
      end
      S_MWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_REX: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = REGDST_RD;
      end
      S_BEQ: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
      end
      S_JMP: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
      end
      S_IEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_IMM;
      end
      S_IWB: begin
        RegWrite = 1'b1;
        RegDst   = REGDST_RT;
      end
`ifdef MULTI_CTRL_JAL_EN
      S_JAL: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
        RegWrite = 1'b1;
        RegDst   = REGDST_RA;
      end
`endif
      default: ;
    endcase
  end

  assign state   = r_state;
  assign mem_err = r_mem_err;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Bench for multi_cycle_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_multi_cycle_ctrl;

  localparam int TMO = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cpu_en = 1'b0;
  logic [5:0] op = 6'd0;
  logic       mem_ready = 1'b0;

  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic       IRWrite, ALUSrcA, RegWrite;
  logic [1:0] PCSource, ALUOp, ALUSrcB, RegDst;
  logic [3:0] state;
  logic       illegal, mem_err;

  multi_cycle_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .cpu_en(cpu_en), .op(op), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
    .PCSource(PCSource), .ALUOp(ALUOp), .ALUSrcB(ALUSrcB), .RegDst(RegDst),
    .state(state), .illegal(illegal), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Where ID sends an opcode; 0 means back to fetch (illegal).
  function automatic int spec_target(input logic [5:0] o);
    case (o)
      6'd0:       return 6;
      6'd35, 6'd43: return 2;
      6'd4:       return 8;
      6'd2:       return 9;
      6'd8, 6'd13: return 10;
`ifdef MULTI_CTRL_JAL_EN
      6'd3:       return 12;
`endif
      default:    return 0;
    endcase
  endfunction

  function automatic int spec_next(input int st, input logic [5:0] o,
                                   input logic ce, input logic mr);
    case (st)
      0:  return (ce && mr) ? 1 : 0;
      1:  return spec_target(o);
      2:  return (o == 6'd35) ? 3 : 5;
      3:  return mr ? 4 : 3;
      5:  return mr ? 0 : 5;
      6:  return 7;
      10: return 11;
      default: return 0;
    endcase
  endfunction

  function automatic logic [17:0] spec_ctrl(input int st, input logic ce,
                                            input logic mr, input logic [5:0] o);
    logic pcw = 0, pcwc = 0, iord = 0, mrd = 0, mwr = 0, m2r = 0;
    logic irw = 0, srca = 0, rw = 0, ill = 0;
    logic [1:0] pcsrc = 0, aluop = 0, srcb = 0, rdst = 0;
    case (st)
      0:  begin mrd = ce; srcb = 2'b01; pcw = ce & mr; irw = ce & mr; end
      1:  begin srcb = 2'b11; ill = (spec_target(o) == 0); end
      2:  begin srca = 1; srcb = 2'b10; end
      3:  begin iord = 1; mrd = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin iord = 1; mwr = 1; end
      6:  begin srca = 1; aluop = 2'b10; end
      7:  begin rw = 1; rdst = 2'b01; end
      8:  begin srca = 1; aluop = 2'b01; pcwc = 1; pcsrc = 2'b01; end
      9:  begin pcw = 1; pcsrc = 2'b10; end
      10: begin srca = 1; srcb = 2'b10; aluop = 2'b11; end
      11: begin rw = 1; end
      12: begin pcw = 1; pcsrc = 2'b10; rw = 1; rdst = 2'b10; end
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, m2r, irw, srca, rw, pcsrc, aluop, srcb, rdst, ill};
  endfunction

  int   m_state, m_wait;
  logic m_err;
  logic m_waiting;
  assign m_waiting = (((m_state == 0) && cpu_en) || (m_state == 3) || (m_state == 5)) && !mem_ready;

  // Model: a stall run of TMO cycles aborts to fetch with a one-cycle error.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state <= 0; m_wait <= 0; m_err <= 1'b0;
    end else if (m_waiting && (m_wait + 1 == TMO)) begin
      m_state <= 0; m_wait <= 0; m_err <= 1'b1;
    end else begin
      m_err   <= 1'b0;
      m_wait  <= m_waiting ? m_wait + 1 : 0;
      m_state <= spec_next(m_state, op, cpu_en, mem_ready);
    end
  end

  logic [17:0] dut_ctrl;
  assign dut_ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                     ALUSrcA, RegWrite, PCSource, ALUOp, ALUSrcB, RegDst, illegal};

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("ctrl", 32'(dut_ctrl), 32'(spec_ctrl(m_state, cpu_en, mem_ready, op)));
      check("state", 32'(state), 32'(m_state));
      check("mem_err", 32'(mem_err), 32'(m_err));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [5:0] op_pool [9] = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd2, 6'd8, 6'd13, 6'd3, 6'd63};

  function automatic logic [5:0] pick_op();
    int unsigned k = $urandom_range(0, 9);
    if (k == 9) return 6'($urandom);
    return op_pool[k];
  endfunction

  int got_s [5];
  int got_rw [5];
  int exp_s [5] = '{0, 1, 6, 7, 0};
  int exp_rw [5] = '{0, 0, 0, 1, 0};
  int n;
  int stuck;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("rst_state", 32'(state), 0);
    check("rst_mem_err", 32'(mem_err), 0);
    rst = 1'b0;

    // Idle after reset with cpu_en low.
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_state", 32'(state), 0);
      check("idle_enables", 32'({PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
                                 MemtoReg, IRWrite, RegWrite}), 0);
    end

    // R-type walk.
    op = 6'b000000; cpu_en = 1'b1; mem_ready = 1'b1; #1;
    for (int i = 0; i < 5; i++) begin
      got_s[i]  = int'(state);
      got_rw[i] = int'(RegWrite);
      if (i < 4) tick();
    end
    cpu_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("rtype_seq", 32'(got_s[i]), 32'(exp_s[i]));
      check("rtype_regwrite", 32'(got_rw[i]), 32'(exp_rw[i]));
    end
    tick();

    // Load with three stalled cycles in MRD.
    op = 6'b100011; cpu_en = 1'b1; mem_ready = 1'b1;
    tick(); check("lw_id", 32'(state), 1);
    cpu_en = 1'b0;
    tick(); check("lw_ma", 32'(state), 2);
    tick(); check("lw_mrd", 32'(state), 3);
    mem_ready = 1'b0; #1;
    n = 0;
    for (int k = 0; k < 3; k++) begin
      if (state == 4'd3 && MemRead) n++;
      tick();
    end
    mem_ready = 1'b1; #1;
    if (state == 4'd3 && MemRead) n++;
    check("lw_mrd_hold", 32'(n), 4);
    tick();
    check("lw_mwb_state", 32'(state), 4);
    check("lw_mwb_wr", 32'({RegWrite, MemtoReg}), 32'b11);
    tick();
    check("lw_back_if", 32'(state), 0);

    // Store that never completes: full timeout in MWR.
    op = 6'b101011; cpu_en = 1'b1; mem_ready = 1'b1;
    tick(); cpu_en = 1'b0;
    tick();
    tick(); check("sw_mwr", 32'(state), 5);
    mem_ready = 1'b0; #1;
    n = 0;
    while (state == 4'd5 && n < 40) begin
      n++;
      tick();
    end
    check("sw_mwr_cycles", 32'(n), 15);
    check("sw_tmo_state", 32'(state), 0);
    check("sw_tmo_err", 32'(mem_err), 1);
    tick();
    check("sw_err_pulse", 32'(mem_err), 0);

    // Ready on the very cycle the count would expire completes normally.
    op = 6'b101011; cpu_en = 1'b1; mem_ready = 1'b1;
    tick(); cpu_en = 1'b0;
    tick();
    tick();
    mem_ready = 1'b0;
    repeat (14) tick();
    mem_ready = 1'b1; #1;
    check("edge_mwr", 32'(state), 5);
    tick();
    check("edge_state", 32'(state), 0);
    check("edge_no_err", 32'(mem_err), 0);

    // Illegal opcode.
    op = 6'b111111; cpu_en = 1'b1; mem_ready = 1'b1;
    tick();
    check("ill_flag", 32'(illegal), 1);
    check("ill_no_wr", 32'({PCWrite, PCWriteCond, MemWrite, RegWrite, IRWrite}), 0);
    cpu_en = 1'b0;
    tick();
    check("ill_next", 32'(state), 0);
    check("ill_clear", 32'(illegal), 0);

    // JAL opcode, configuration dependent.
    op = 6'b000011; cpu_en = 1'b1; mem_ready = 1'b1;
    tick(); cpu_en = 1'b0;
    check("jal_id", 32'(state), 1);
`ifdef MULTI_CTRL_JAL_EN
    check("jal_legal", 32'(illegal), 0);
    tick();
    check("jal_state", 32'(state), 12);
    check("jal_ctrl", 32'({PCWrite, RegWrite, PCSource, RegDst, MemtoReg}), 32'b11_10_10_0);
`else
    check("jal_illegal", 32'(illegal), 1);
`endif
    tick();
    check("jal_done", 32'(state), 0);

    // Reset mid-store abandons the access immediately.
    op = 6'b101011; cpu_en = 1'b1; mem_ready = 1'b1;
    tick(); cpu_en = 1'b0;
    tick();
    tick();
    mem_ready = 1'b0; #1;
    check("rst_mid_mw", 32'(MemWrite), 1);
    rst = 1'b1; #1;
    check("rst_async_state", 32'(state), 0);
    check("rst_async_mw", 32'({MemWrite, RegWrite, mem_err}), 0);
    tick();
    rst = 1'b0;
    tick();
    check("rst_after_state", 32'(state), 0);
    check("rst_after_mw", 32'(MemWrite), 0);

    // Randomized traffic; the per-cycle compare process does the checking.
    stuck = 0;
    for (int c = 0; c < 4000; c++) begin
      if (stuck > 0) begin
        mem_ready = 1'b0;
        stuck--;
      end else begin
        if ($urandom_range(0, 49) == 0) stuck = int'($urandom_range(10, 20));
        mem_ready = ($urandom_range(0, 3) != 0);
      end
      cpu_en = ($urandom_range(0, 7) != 0);
      op = pick_op();
      if ($urandom_range(0, 399) == 0) begin
        #2 rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
